lista_candidatos: RTL and testbench

LISTA_CANDIDATOS -- requirements
Module: lista_candidatos

---
 rtl/dijkstra_pkg.sv | 44 ++++
 rtl/seletor_menor.sv | 42 ++++
 rtl/lista_candidatos.sv | 184 ++++++++++++++++++
 tb/tb_lista_candidatos.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dijkstra_pkg.sv
// Shared widths, FSM encoding and candidate-entry record for the path-search blocks.
// LISTA_CANDIDATOS_HEURISTICA_EN adds the onward-cost field to the entry and to the pop key.
package dijkstra_pkg;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DIST_W  = 6;
  localparam int unsigned CUSTO_W = 4;
  localparam int unsigned NUM_ENT = 16;
  // One extra bit so distancia+custo can never wrap.
  localparam int unsigned KEY_W   = DIST_W + 1;

  localparam logic [ADDR_W-1:0] NO_NODE = '1;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_INSERIR      = 2'd1,
    ST_BUSCAR_MENOR = 2'd2,
    ST_ENTREGAR     = 2'd3
  } estado_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  endereco;
    logic [DIST_W-1:0]  distancia;
`ifdef LISTA_CANDIDATOS_HEURISTICA_EN
    logic [CUSTO_W-1:0] custo;
`endif
    logic [ADDR_W-1:0]  anterior;
  } dados_t;

  typedef struct packed {
    logic   valido;
    dados_t dados;
  } entrada_t;

  // Ordering key used by the minimum scan.
  function automatic logic [KEY_W-1:0] chave_de(input dados_t d);
`ifdef LISTA_CANDIDATOS_HEURISTICA_EN
    return KEY_W'(d.distancia) + KEY_W'(d.custo);
`else
    return KEY_W'(d.distancia);
`endif
  endfunction

endpackage

// File: rtl/seletor_menor.sv
// Sequential minimum finder: walks one table entry per cycle while ativo is high and
// remembers the lowest key seen among valid entries (first index wins on ties).
module seletor_menor
  import dijkstra_pkg::*;
#(
  parameter int unsigned NUM_ENTRADAS = NUM_ENT,
  parameter int unsigned CHAVE_W      = KEY_W,
  parameter int unsigned IDX_W        = $clog2(NUM_ENTRADAS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ativo,
  input  logic               candidato_valido,
  input  logic [CHAVE_W-1:0] chave,
  output logic [IDX_W-1:0]   indice,
  output logic               ultimo_c,
  output logic               achou,
  output logic [IDX_W-1:0]   indice_menor
);

  logic [CHAVE_W-1:0] chave_menor;

  assign ultimo_c = (indice == IDX_W'(NUM_ENTRADAS - 1));

  // Outside a scan everything is held cleared so the next scan starts at index 0.
  always_ff @(posedge clk) begin
    if (rst || !ativo) begin
      indice       <= '0;
      achou        <= 1'b0;
      chave_menor  <= '1;
      indice_menor <= '0;
    end else begin
      indice <= indice + IDX_W'(1);
      if (candidato_valido && (!achou || (chave < chave_menor))) begin
        achou        <= 1'b1;
        chave_menor  <= chave;
        indice_menor <= indice;
      end
    end
  end

endmodule

// File: rtl/lista_candidatos.sv
// Candidate list for the shortest-path engine: merges tentative distances per node and
// pops the cheapest node on request. Define LISTA_CANDIDATOS_HEURISTICA_EN to key on distancia+custo.
module lista_candidatos
  import dijkstra_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = ADDR_W,
  parameter int unsigned DISTANCIA_WIDTH = DIST_W,
  parameter int unsigned CUSTO_WIDTH     = CUSTO_W,
  parameter int unsigned NUM_ENTRADAS    = NUM_ENT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ea_atualizar_in,
  input  logic [ADDR_WIDTH-1:0]      ea_endereco_in,
  input  logic [DISTANCIA_WIDTH-1:0] ea_distancia_in,
  input  logic [CUSTO_WIDTH-1:0]     ea_menor_vizinho_in,
  input  logic [ADDR_WIDTH-1:0]      ea_anterior_in,
  input  logic                       lvv_pedir_menor_in,
  output logic                       lc_ocupado_out,
  output logic                       lc_menor_valido_out,
  output logic [ADDR_WIDTH-1:0]      lc_menor_addr_out,
  output logic [DISTANCIA_WIDTH-1:0] lc_menor_distancia_out,
  output logic [ADDR_WIDTH-1:0]      lc_menor_anterior_out,
  output logic                       lc_vazio_out,
  output logic                       lc_cheio_out,
  output logic                       lc_overflow_out
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRADAS);

  estado_t                 estado, estado_prox;
  logic                    pendente, pendente_prox;
  logic                    capturar, ativo;
  entrada_t                tabela [NUM_ENTRADAS];
  dados_t                  captura;
  logic [NUM_ENTRADAS-1:0] validos;
  logic                    casou, livre;
  logic [IDX_W-1:0]        idx_casou, idx_livre;
  logic [IDX_W-1:0]        indice, indice_menor;
  logic                    ultimo_c, achou;
  logic                    candidato_valido;
  logic [KEY_W-1:0]        chave;

`ifndef LISTA_CANDIDATOS_HEURISTICA_EN
  logic [CUSTO_WIDTH-1:0] unused_custo;
  assign unused_custo = ea_menor_vizinho_in;
`endif

  always_comb begin
    validos = '0;
    for (int i = 0; i < NUM_ENTRADAS; i++) validos[i] = tabela[i].valido;
  end

  assign lc_vazio_out = ~|validos;
  assign lc_cheio_out = &validos;

  // Parallel address match and lowest free slot; descending walk leaves the lowest index.
  always_comb begin
    casou     = 1'b0;
    idx_casou = '0;
    livre     = 1'b0;
    idx_livre = '0;
    for (int i = int'(NUM_ENTRADAS) - 1; i >= 0; i--) begin
      if (validos[i] && (tabela[i].dados.endereco == captura.endereco)) begin
        casou     = 1'b1;
        idx_casou = IDX_W'(i);
      end
      if (!validos[i]) begin
        livre     = 1'b1;
        idx_livre = IDX_W'(i);
      end
    end
  end

  assign candidato_valido = tabela[indice].valido;
  assign chave            = chave_de(tabela[indice].dados);

  seletor_menor #(
    .NUM_ENTRADAS (NUM_ENTRADAS),
    .CHAVE_W      (KEY_W),
    .IDX_W        (IDX_W)
  ) u_seletor (
    .clk              (clk),
    .rst              (rst),
    .ativo            (ativo),
    .candidato_valido (candidato_valido),
    .chave            (chave),
    .indice           (indice),
    .ultimo_c         (ultimo_c),
    .achou            (achou),
    .indice_menor     (indice_menor)
  );

  // Next-state logic; an update beats a simultaneous pop, which is parked as pending.
  always_comb begin
    estado_prox   = estado;
    pendente_prox = pendente;
    capturar      = 1'b0;
    ativo         = 1'b0;
    case (estado)
      ST_IDLE: begin
        if (pendente) begin
          pendente_prox = 1'b0;
          estado_prox   = ST_BUSCAR_MENOR;
        end else if (ea_atualizar_in) begin
          capturar    = 1'b1;
          estado_prox = ST_INSERIR;
          if (lvv_pedir_menor_in) pendente_prox = 1'b1;
        end else if (lvv_pedir_menor_in) begin
          estado_prox = ST_BUSCAR_MENOR;
        end
      end
      ST_INSERIR: estado_prox = ST_IDLE;
      ST_BUSCAR_MENOR: begin
        ativo = 1'b1;
        if (ultimo_c) estado_prox = ST_ENTREGAR;
      end
      ST_ENTREGAR: estado_prox = ST_IDLE;
      default: estado_prox = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado         <= ST_IDLE;
      pendente       <= 1'b0;
      lc_ocupado_out <= 1'b0;
    end else begin
      estado         <= estado_prox;
      pendente       <= pendente_prox;
      lc_ocupado_out <= (estado_prox != ST_IDLE) || pendente_prox;
    end
  end

  // Table storage, capture register and pop result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRADAS; i++) tabela[i] <= '0;
      captura                <= '0;
      lc_overflow_out        <= 1'b0;
      lc_menor_valido_out    <= 1'b0;
      lc_menor_addr_out      <= '0;
      lc_menor_distancia_out <= '0;
      lc_menor_anterior_out  <= '0;
    end else begin
      lc_menor_valido_out <= 1'b0;

      if (capturar) begin
        captura.endereco  <= ea_endereco_in;
        captura.distancia <= ea_distancia_in;
`ifdef LISTA_CANDIDATOS_HEURISTICA_EN
        captura.custo     <= ea_menor_vizinho_in;
`endif
        captura.anterior  <= ea_anterior_in;
      end

      if (estado == ST_INSERIR) begin
        if (casou) begin
          if (captura.distancia < tabela[idx_casou].dados.distancia)
            tabela[idx_casou].dados <= captura;
        end else if (livre) begin
          tabela[idx_livre] <= '{valido: 1'b1, dados: captura};
        end else begin
          lc_overflow_out <= 1'b1;
        end
      end

      if (estado == ST_ENTREGAR) begin
        lc_menor_valido_out <= 1'b1;
        if (achou) begin
          lc_menor_addr_out             <= tabela[indice_menor].dados.endereco;
          lc_menor_distancia_out        <= tabela[indice_menor].dados.distancia;
          lc_menor_anterior_out         <= tabela[indice_menor].dados.anterior;
          tabela[indice_menor].valido   <= 1'b0;
        end else begin
          lc_menor_addr_out      <= NO_NODE;
          lc_menor_distancia_out <= '1;
          lc_menor_anterior_out  <= NO_NODE;
        end
      end
    end
  end

endmodule

// File: tb/tb_lista_candidatos.sv
// Bench for lista_candidatos: directed scenarios plus random traffic against a
// table-level model of the candidate list.
module tb_lista_candidatos;
  import dijkstra_pkg::*;

  localparam int unsigned N   = 16;
  localparam int unsigned LAT = N + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       upd = 1'b0;
  logic [9:0] e_addr = '0;
  logic [5:0] e_dist = '0;
  logic [3:0] e_custo = '0;
  logic [9:0] e_ant = '0;
  logic       pop = 1'b0;
  logic       ocupado, valido, vazio, cheio, ovf;
  logic [9:0] m_addr, m_ant;
  logic [5:0] m_dist;

  always #5 clk = ~clk;

  lista_candidatos dut (
    .clk                    (clk),
    .rst                    (rst),
    .ea_atualizar_in        (upd),
    .ea_endereco_in         (e_addr),
    .ea_distancia_in        (e_dist),
    .ea_menor_vizinho_in    (e_custo),
    .ea_anterior_in         (e_ant),
    .lvv_pedir_menor_in     (pop),
    .lc_ocupado_out         (ocupado),
    .lc_menor_valido_out    (valido),
    .lc_menor_addr_out      (m_addr),
    .lc_menor_distancia_out (m_dist),
    .lc_menor_anterior_out  (m_ant),
    .lc_vazio_out           (vazio),
    .lc_cheio_out           (cheio),
    .lc_overflow_out        (ovf)
  );

  typedef struct {
    bit          v;
    int unsigned a, d, c, p;
  } ment_t;

  ment_t       mdl [N];
  bit          m_ovf;
  int          vetores, falhas;
  bit          esperado, exp_found;
  int unsigned exp_addr, exp_dist, exp_ant, exp_idx;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    vetores++;
    if (got !== exp) begin
      falhas++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, got, exp, $time);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < N; i++) mdl[i].v = 1'b0;
    m_ovf = 1'b0;
  endfunction

  function automatic void m_update(input int unsigned a, d, c, p);
    for (int i = 0; i < N; i++)
      if (mdl[i].v && mdl[i].a == a) begin
        if (d < mdl[i].d) begin
          mdl[i].d = d; mdl[i].c = c; mdl[i].p = p;
        end
        return;
      end
    for (int i = 0; i < N; i++)
      if (!mdl[i].v) begin
        mdl[i].v = 1'b1; mdl[i].a = a; mdl[i].d = d; mdl[i].c = c; mdl[i].p = p;
        return;
      end
    m_ovf = 1'b1;
  endfunction

  function automatic int unsigned m_key(input int i);
`ifdef LISTA_CANDIDATOS_HEURISTICA_EN
    return mdl[i].d + mdl[i].c;
`else
    return mdl[i].d;
`endif
  endfunction

  function automatic void m_predict();
    exp_found = 1'b0; exp_idx = 0;
    exp_addr = 'h3FF; exp_dist = 'h3F; exp_ant = 'h3FF;
    for (int i = 0; i < N; i++)
      if (mdl[i].v && (!exp_found || m_key(i) < m_key(int'(exp_idx)))) begin
        exp_found = 1'b1;
        exp_idx   = i;
      end
    if (exp_found) begin
      exp_addr = mdl[exp_idx].a; exp_dist = mdl[exp_idx].d; exp_ant = mdl[exp_idx].p;
    end
  endfunction

  function automatic bit m_empty();
    for (int i = 0; i < N; i++) if (mdl[i].v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < N; i++) if (!mdl[i].v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (esperado) begin
        chk("pulse_valid", 32'(valido), 32'd1);
        chk("pulse_addr", 32'(m_addr), exp_addr);
        chk("pulse_dist", 32'(m_dist), exp_dist);
        if (exp_found) chk("pulse_ant", 32'(m_ant), exp_ant);
      end else begin
        chk("no_pulse", 32'(valido), 32'd0);
      end
      if (!rst && !ocupado) begin
        chk("vazio", 32'(vazio), 32'(m_empty()));
        chk("cheio", 32'(cheio), 32'(m_full()));
        chk("overflow", 32'(ovf), 32'(m_ovf));
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ocupado && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (ocupado) begin
      vetores++; falhas++;
      $display("FAIL wait_idle: ocupado got 1 expected 0 after 100 cycles");
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    m_clear();
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_fields(input int unsigned a, d, c, p);
    e_addr = 10'(a); e_dist = 6'(d); e_custo = 4'(c); e_ant = 10'(p);
  endtask

  task automatic do_update(input int unsigned a, d, c, p);
    wait_idle();
    upd = 1'b1;
    drive_fields(a, d, c, p);
    @(posedge clk); #1;
    upd = 1'b0;
    m_update(a, d, c, p);
  endtask

  // Optionally throws a stray update at the block mid-scan; it must be ignored.
  task automatic do_pop(input bit ruido);
    wait_idle();
    pop = 1'b1;
    m_predict();
    @(posedge clk); #1;
    pop = 1'b0;
    if (ruido) begin
      upd = 1'b1;
      drive_fields('h2AA, 0, 0, 'h155);
      @(posedge clk); #1;
      upd = 1'b0;
      repeat (LAT - 2) @(posedge clk);
    end else begin
      repeat (LAT - 1) @(posedge clk);
    end
    #1;
    esperado = 1'b1;
    if (exp_found) mdl[exp_idx].v = 1'b0;
    @(posedge clk); #1;
    esperado = 1'b0;
  endtask

  // Update and pop in the same cycle: insert, one idle cycle, then the full scan.
  task automatic do_combo(input int unsigned a, d, c, p);
    wait_idle();
    upd = 1'b1; pop = 1'b1;
    drive_fields(a, d, c, p);
    @(posedge clk); #1;
    upd = 1'b0; pop = 1'b0;
    m_update(a, d, c, p);
    m_predict();
    repeat (LAT + 1) @(posedge clk);
    #1;
    esperado = 1'b1;
    if (exp_found) mdl[exp_idx].v = 1'b0;
    @(posedge clk); #1;
    esperado = 1'b0;
  endtask

  task automatic do_abort();
    wait_idle();
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    do_reset(1);
  endtask

  initial begin
    vetores = 0; falhas = 0; esperado = 1'b0;
    m_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_vazio", 32'(vazio), 32'd1);
    chk("rst_cheio", 32'(cheio), 32'd0);
    chk("rst_overflow", 32'(ovf), 32'd0);
    chk("rst_valid", 32'(valido), 32'd0);
    chk("rst_addr", 32'(m_addr), 32'd0);
    chk("rst_dist", 32'(m_dist), 32'd0);
    chk("rst_ant", 32'(m_ant), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);

    fork
      monitor();
    join_none

    // Single insert then pop
    do_update(5, 10, 2, 100);
    do_pop(1'b0);
    chk("s1_addr", exp_addr, 32'd5);
    chk("s1_dist", exp_dist, 32'd10);
    chk("s1_vazio", 32'(vazio), 32'd1);

    // Repeated updates to one node keep the smallest distance
    do_update(7, 20, 1, 40);
    do_update(7, 12, 1, 41);
    do_update(7, 15, 1, 42);
    do_pop(1'b0);
    chk("s2_dist", exp_dist, 32'd12);
    chk("s2_ant", exp_ant, 32'd41);

    // Fill, overflow, drain
    do_reset(2);
    for (int i = 1; i <= 16; i++) do_update(i, 60 - i, 3, i + 200);
    do_update(17, 1, 0, 300);
    wait_idle();
    chk("s3_cheio", 32'(cheio), 32'd1);
    chk("s3_overflow", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) begin
      do_pop(1'(i % 2));
      chk("s3_not17", 32'(exp_addr == 17), 32'd0);
    end
    chk("s3_vazio", 32'(vazio), 32'd1);
    chk("s3_overflow_sticky", 32'(ovf), 32'd1);

    // Key selection with and without onward cost
    do_reset(2);
    do_update(3, 8, 5, 1);
    do_update(4, 9, 1, 2);
    do_pop(1'b0);
`ifdef LISTA_CANDIDATOS_HEURISTICA_EN
    chk("s4_addr", exp_addr, 32'd4);
`else
    chk("s4_addr", exp_addr, 32'd3);
`endif
    do_pop(1'b0);

    // Empty pop
    do_reset(2);
    do_pop(1'b0);
    chk("s5_addr", exp_addr, 32'h3FF);
    chk("s5_dist", exp_dist, 32'h3F);

    // Update and pop together, then reset mid-scan
    do_update(9, 30, 0, 1);
    do_combo(2, 5, 3, 7);
    chk("s6_addr", exp_addr, 32'd2);
    do_update(11, 4, 4, 4);
    do_abort();
    chk("s6_abort_vazio", 32'(vazio), 32'd1);
    repeat (25) @(posedge clk);
    #1;

    // Random traffic
    for (int k = 0; k < 260; k++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (k == 130) do_reset(2);
      if (r <= 5)
        do_update($urandom_range(0, 20), $urandom_range(0, 63), $urandom_range(0, 15),
                  $urandom_range(0, 1023));
      else if (r <= 8)
        do_pop(1'($urandom_range(0, 1)));
      else
        do_combo($urandom_range(0, 20), $urandom_range(0, 63), $urandom_range(0, 15),
                 $urandom_range(0, 1023));
    end

    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vetores, falhas);
    $finish;
  end

endmodule
